pc_next_unit: RTL

Program-counter and branch-resolution stage downstream of the 64-bit ALU. It consumes the ALU zero flag together with the branch controls of the instruction currently in execute. It computes the next PC: sequential, unconditional B, or CBZ-taken. It owns the PC register, drives the fetch address and valid to instruction memory, and issues a one-cycle flush on redirect.

---
 rtl/pc_next_unit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pc_next_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_unit
// Description : Program counter and branch resolution. Selects the next fetch
//               address (sequential, unconditional B, taken CBZ), owns the PC
//               register, drives fetch address/valid toward instruction
//               memory, emits a one-cycle flush on redirect or halt, and keeps
//               a saturating count of taken branches.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             ex_valid,
    input  logic [63:0]      ex_pc,
    input  logic             ex_branch,
    input  logic             ex_zero_branch,
    input  logic             ex_halt,
    input  logic [63:0]      ex_offset,
    input  logic             zero,
    output logic [63:0]      pc,
    output logic [63:0]      pc_plus4,
    output logic             fetch_valid,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] taken_count
);

    // RUN fetches, REDIRECT is the single bubble after a taken branch,
    // HALT is terminal until reset.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    localparam logic [63:0]      c_pc_step = 64'd4;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [63:0]      r_pc;
    logic [63:0]      w_pc_nxt;
    logic             r_flush;
    logic             w_flush_nxt;
    logic [CNT_W-1:0] r_taken_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] w_count_sat_inc;

    logic             w_taken;
    logic             w_halt_req;
    logic [63:0]      w_offset_bytes;
    logic [63:0]      w_target;
    logic [63:0]      w_pc_seq;
    logic             w_fetch_valid;
    logic             w_halted;

    // Branch qualification; B wins when both branch flavours are set.
    assign w_taken    = ex_valid & (ex_branch | (ex_zero_branch & zero));
    assign w_halt_req = ex_valid & ex_halt;

    // Word offset to byte offset; the sum wraps modulo 2^64 by design.
    assign w_offset_bytes = ex_offset << 2;
    assign w_target       = ex_pc + w_offset_bytes;
    assign w_pc_seq       = r_pc + c_pc_step;

    // Counter holds at all-ones instead of wrapping.
    assign w_count_sat_inc = (r_taken_count == c_cnt_max) ? r_taken_count
                                                          : r_taken_count + c_cnt_one;

    // Next-state, next-PC and output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_flush_nxt   = 1'b0;
        w_count_nxt   = r_taken_count;
        w_fetch_valid = 1'b0;
        w_halted      = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_fetch_valid = 1'b1;
                if (w_halt_req) begin
                    // PC holds; younger instructions are killed.
                    w_flush_nxt = 1'b1;
                    w_state_nxt = ST_HALT;
                end else if (w_taken) begin
                    // A taken branch overrides a fetch-side stall.
                    w_pc_nxt    = w_target;
                    w_flush_nxt = 1'b1;
                    w_count_nxt = w_count_sat_inc;
                    w_state_nxt = ST_REDIRECT;
                end else if (!stall) begin
                    w_pc_nxt = w_pc_seq;
                end
            end
            ST_REDIRECT: begin
                // Upstream was flushed, so execute-stage inputs are stale.
                w_state_nxt = ST_RUN;
            end
            ST_HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // State, PC, flush and statistics registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_flush       <= 1'b0;
            r_taken_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_flush       <= w_flush_nxt;
            r_taken_count <= w_count_nxt;
        end
    end

    // Fetch is suppressed for the whole time reset is held.
    assign fetch_valid = w_fetch_valid & ~rst;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_seq;
    assign flush       = r_flush;
    assign halted      = w_halted;
    assign taken_count = r_taken_count;

endmodule
`default_nettype wire
